// File: rtl/core_mem_driver.sv
// Controller end of a core-memory drive/sense interface: decodes the word address onto four
// one-hot active-low drive groups and sequences the destructive-read and restore/write phases.
module core_mem_driver #(
  parameter int SETUP_CYC = 2,
  parameter int READ_CYC  = 8,
  parameter int SENSE_AT  = 5,
  parameter int GAP_CYC   = 1,
  parameter int WRITE_CYC = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WRITE,
  input  logic [11:0] ADDR,
  input  logic        WDATA,
  output logic        BUSY,
  output logic        ACK,
  output logic        RDATA,
  output logic        SENSE_ERR,
  output logic [7:0]  AnAXVN,
  output logic [7:0]  AnAYVN,
  output logic [7:0]  AnAX0VN,
  output logic [7:0]  AnAY0VN,
  output logic        AnRDMV,
  output logic        AnRDMVN,
  output logic        MmSYNCV,
  output logic        AnINHBSV,
  input  logic        EDmX,
  input  logic        EDmY
);

  localparam int CW = 8;

  typedef enum logic [2:0] {stIdle, stSetup, stRead, stGap, stWrite, stDone} state_t;

  state_t          state, nextState;
  logic [CW-1:0]   phaseCnt;
  logic [11:0]     addrLat, addrNext;
  logic            wrLat, wrNext, wdLat, wdNext;
  logic            sx, sy, sxNext, syNext;
  logic            accept, senseNow, restoreNext, driving, stateChange;

  always_comb begin
    nextState = state;
    unique case (state)
      stIdle:  if (REQ) nextState = stSetup;
      stSetup: if (phaseCnt == CW'(SETUP_CYC - 1)) nextState = stRead;
      stRead:  if (phaseCnt == CW'(READ_CYC - 1)) nextState = (GAP_CYC == 0) ? stWrite : stGap;
      stGap:   if (phaseCnt == CW'(GAP_CYC - 1)) nextState = stWrite;
      stWrite: if (phaseCnt == CW'(WRITE_CYC - 1)) nextState = stDone;
      stDone:  nextState = stIdle;
      default: nextState = stIdle;
    endcase

    accept   = (state == stIdle) && REQ;
    addrNext = accept ? ADDR  : addrLat;
    wrNext   = accept ? WRITE : wrLat;
    wdNext   = accept ? WDATA : wdLat;

    // Sense accumulators restart on entry to READ and only listen from SENSE_AT onward.
    senseNow = (state == stRead) && (phaseCnt >= CW'(SENSE_AT));
    if (nextState == stRead && state != stRead) begin
      sxNext = 1'b0;
      syNext = 1'b0;
    end else begin
      sxNext = sx | (senseNow & EDmX);
      syNext = sy | (senseNow & EDmY);
    end

    restoreNext = wrNext ? wdNext : sxNext;
    driving     = (nextState == stSetup) || (nextState == stRead) ||
                  (nextState == stGap)   || (nextState == stWrite);
    stateChange = (nextState != state);
  end

  // All outputs are registered from the next-state decode so drive lines switch cleanly on edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= stIdle;
      phaseCnt  <= '0;
      addrLat   <= '0;
      wrLat     <= 1'b0;
      wdLat     <= 1'b0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      BUSY      <= 1'b0;
      ACK       <= 1'b0;
      RDATA     <= 1'b0;
      SENSE_ERR <= 1'b0;
      AnAXVN    <= 8'hFF;
      AnAYVN    <= 8'hFF;
      AnAX0VN   <= 8'hFF;
      AnAY0VN   <= 8'hFF;
      AnRDMV    <= 1'b0;
      AnRDMVN   <= 1'b0;
      MmSYNCV   <= 1'b0;
      AnINHBSV  <= 1'b0;
    end else begin
      state    <= nextState;
      phaseCnt <= stateChange ? '0 : phaseCnt + 1'b1;
      addrLat  <= addrNext;
      wrLat    <= wrNext;
      wdLat    <= wdNext;
      sx       <= sxNext;
      sy       <= syNext;
      BUSY     <= (nextState != stIdle);
      ACK      <= (nextState == stDone);
      if (nextState == stDone) begin
        RDATA     <= sxNext;
        SENSE_ERR <= sxNext ^ syNext;
      end
      AnAXVN   <= driving ? ~(8'd1 << addrNext[2:0]) : 8'hFF;
      AnAYVN   <= driving ? ~(8'd1 << addrNext[5:3]) : 8'hFF;
      AnAX0VN  <= driving ? ~(8'd1 << addrNext[8:6]) : 8'hFF;
      AnAY0VN  <= driving ? ~(8'd1 << addrNext[11:9]) : 8'hFF;
      AnRDMV   <= (nextState == stRead);
      AnRDMVN  <= (nextState == stWrite);
      MmSYNCV  <= stateChange && ((nextState == stRead) || (nextState == stWrite));
      AnINHBSV <= (nextState == stWrite) && !restoreNext;
    end
  end

endmodule

// File: tb/tb_core_mem_driver.sv
// Directed and random accesses against a cycle-timeline model of the core-memory driver.
module tb_core_mem_driver;

  localparam int S = 2, R = 8, SA = 5, G = 1, W = 8;
  localparam int LAT = 1 + S + R + G + W;

  logic        CLK = 1'b0;
  logic        RESET, REQ, WRITE, WDATA, EDmX, EDmY;
  logic [11:0] ADDR;
  logic        BUSY, ACK, RDATA, SENSE_ERR, AnRDMV, AnRDMVN, MmSYNCV, AnINHBSV;
  logic [7:0]  AnAXVN, AnAYVN, AnAX0VN, AnAY0VN;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lastAccept = 0;
  logic prevRd = 1'b0, prevErr = 1'b0;

  core_mem_driver #(.SETUP_CYC(S), .READ_CYC(R), .SENSE_AT(SA), .GAP_CYC(G), .WRITE_CYC(W)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WRITE(WRITE), .ADDR(ADDR), .WDATA(WDATA),
    .BUSY(BUSY), .ACK(ACK), .RDATA(RDATA), .SENSE_ERR(SENSE_ERR),
    .AnAXVN(AnAXVN), .AnAYVN(AnAYVN), .AnAX0VN(AnAX0VN), .AnAY0VN(AnAY0VN),
    .AnRDMV(AnRDMV), .AnRDMVN(AnRDMVN), .MmSYNCV(MmSYNCV), .AnINHBSV(AnINHBSV),
    .EDmX(EDmX), .EDmY(EDmY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  wire [31:0] drives = {AnAY0VN, AnAX0VN, AnAYVN, AnAXVN};
  wire [7:0]  ctrl   = {BUSY, ACK, AnRDMV, AnRDMVN, MmSYNCV, AnINHBSV, RDATA, SENSE_ERR};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sel(input logic [2:0] f);
    logic [7:0] v;
    v = 8'hFF;
    v[f] = 1'b0;
    return v;
  endfunction

  // One access, entered and left on a negedge. The model walks the access timeline:
  // r=0 accept (IDLE), then SETUP, READ, GAP, WRITE, and DONE at r=LAT.
  task automatic access(input logic [11:0] a, input logic wr, input logic wd,
                        input logic [7:0] xp, input logic [7:0] yp,
                        input bit hold, input int abortR);
    int guard;
    logic sx, sy, rb, inRead, inWrite, isDone, eRdmv, eRdmvn, eSync, eInh, eRd, eErr;
    logic [31:0] expDrv;
    guard = 0;
    while (BUSY !== 1'b0 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    chk("idle_busy", {31'b0, BUSY}, 32'd0);
    chk("idle_rdata_hold", {30'b0, RDATA, SENSE_ERR}, {30'b0, prevRd, prevErr});
    REQ = 1'b1; ADDR = a; WRITE = wr; WDATA = wd;
    lastAccept = cyc;
    sx = 1'b0; sy = 1'b0;
    for (int k = SA; k < R; k++) begin
      sx = sx | xp[k];
      sy = sy | yp[k];
    end
    rb = wr ? wd : sx;
    for (int r = 1; r <= LAT; r++) begin
      @(negedge CLK);
      ADDR = 12'($urandom); WRITE = 1'($urandom); WDATA = 1'($urandom);
      REQ = hold ? (r != 5) : 1'($urandom);
      inRead  = (r > S) && (r <= S + R);
      inWrite = (r > S + R + G) && (r < LAT);
      isDone  = (r == LAT);
      EDmX = inRead ? xp[r - S - 1] : 1'($urandom);
      EDmY = inRead ? yp[r - S - 1] : 1'($urandom);
      expDrv = isDone ? 32'hFFFF_FFFF : {sel(a[11:9]), sel(a[8:6]), sel(a[5:3]), sel(a[2:0])};
      eRdmv  = inRead;
      eRdmvn = inWrite;
      eSync  = (r == S + 1) || (r == S + R + G + 1);
      eInh   = inWrite && !rb;
      eRd    = isDone ? sx : prevRd;
      eErr   = isDone ? (sx ^ sy) : prevErr;
      chk($sformatf("drv_r%0d", r), drives, expDrv);
      chk($sformatf("ctl_r%0d", r), {24'b0, ctrl},
          {24'b0, 1'b1, isDone, eRdmv, eRdmvn, eSync, eInh, eRd, eErr});
      if (r == abortR) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; REQ = 1'b0;
        chk("abort_drv", drives, 32'hFFFF_FFFF);
        chk("abort_ctl", {24'b0, ctrl}, 32'd0);
        for (int i = 0; i < LAT + 5; i++) begin
          @(negedge CLK);
          chk("abort_quiet", {24'b0, ctrl}, 32'd0);
        end
        prevRd = 1'b0; prevErr = 1'b0;
        return;
      end
    end
    prevRd = sx; prevErr = sx ^ sy;
  endtask

  initial begin
    int a0, a1, a2;
    RESET = 1'b1; REQ = 1'b0; WRITE = 1'b0; WDATA = 1'b0; ADDR = '0; EDmX = 1'b0; EDmY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_drv", drives, 32'hFFFF_FFFF);
    chk("reset_ctl", {24'b0, ctrl}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    access(12'o5273, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 0);    // read, sense high
    chk("t1_rdata", {31'b0, prevRd}, 32'd1);
    access(12'o5273, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0);    // read, sense low
    access(12'o0000, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 0);    // write 0 over an old 1
    access(12'o1234, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0, 0);    // X pulse at read cycle 6
    access(12'o4321, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 0);    // X pulse before SENSE_AT

    access(12'o7070, 1'b0, 1'b0, 8'hE0, 8'hE0, 1'b1, 0);
    a0 = lastAccept;
    access(12'o0707, 1'b1, 1'b1, 8'h00, 8'h20, 1'b1, 0);
    a1 = lastAccept;
    access(12'o3456, 1'b0, 1'b0, 8'h80, 8'h80, 1'b1, 0);
    a2 = lastAccept;
    chk("spacing_1", 32'(a1 - a0), 32'd21);
    chk("spacing_2", 32'(a2 - a1), 32'd21);

    access(12'o6543, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, S + 1 + 4);  // reset at READ cycle 4
    access(12'o2525, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 0);
    chk("after_abort_rdata", {31'b0, prevRd}, 32'd1);

    for (int n = 0; n < 30; n++)
      access(12'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
